spawn_scheduler: RTL and testbench

Obstacle-spawn scheduler for the On-The-Run game. Owns a 4-bit maximal-length LFSR and steps it only when a spawn decision is made. Counts frame ticks between spawns and offers each spawn (lane number) to the obstacle renderer over a valid/ready handshake. Sits between the VGA frame-timing logic and the obstacle object pool.

---
 rtl/spawn_pkg.sv | 20 ++
 rtl/lfsr4_step.sv | 21 ++
 rtl/spawn_scheduler.sv | 130 +++++++++++++
 tb/tb_spawn_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spawn_pkg.sv
// Shared types and helpers for the obstacle-spawn scheduler.
// Holds the FSM state enum, LFSR width, default seed and the LFSR step function.
package spawn_pkg;

    localparam int unsigned LFSR_W = 4;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDraw,
        StOffer
    } spawn_state_t;

    // Maximal-length 4-bit sequence (period 15); all-zero is a lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] r);
        return {r[2:0], r[3] ^ r[0]};
    endfunction

endpackage

// File: rtl/lfsr4_step.sv
// 4-bit LFSR register that advances one step per cycle while `step` is high.
module lfsr4_step
    import spawn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (step) begin
            q <= lfsr4_next(q);
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Obstacle-spawn scheduler: counts frames between spawns, draws lane and gap from an LFSR.
// Optional SPAWN_PAUSE_EN adds a `pause` input that freezes the frame count in WAIT.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int unsigned       NUM_LANES = 3,
    parameter int unsigned       GAP_MIN   = 8,
    parameter int unsigned       GAP_STEP  = 4,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       frame_tick,
`ifdef SPAWN_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [1:0] spawn_lane,
    output logic [3:0] rnd,
    output logic       busy
);

    spawn_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   gap_q, gap_d;
    logic [1:0]   lane_q, lane_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    logic         tick_en;
    logic         lfsr_step;
    logic [3:0]   rnd_post;
    logic [2:0]   lane_raw;
    logic [1:0]   lane_fold;
    logic [7:0]   gap_new;

`ifdef SPAWN_PAUSE_EN
    assign tick_en = frame_tick & ~pause;
`else
    assign tick_en = frame_tick;
`endif

    assign lfsr_step = (state_q == StDraw);

    lfsr4_step #(
        .SEED(SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .step(lfsr_step),
        .q   (rnd)
    );

    // Lane and gap are derived from the value the LFSR takes at the end of DRAW.
    assign rnd_post  = lfsr4_next(rnd);
    assign lane_raw  = {1'b0, rnd_post[1:0]};
    assign lane_fold = (lane_raw >= 3'(NUM_LANES)) ? 2'(lane_raw - 3'(NUM_LANES))
                                                   : rnd_post[1:0];
    assign gap_new   = 8'(GAP_MIN) + 8'(rnd_post[3:2]) * 8'(GAP_STEP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        lane_d  = lane_q;
        valid_d = valid_q;

        if (!run) begin
            // Dropping run wins over a same-cycle handshake.
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWait;
                    cnt_d   = 8'(GAP_MIN);
                end
                StWait: begin
                    if (tick_en) begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = StDraw;
                        end
                    end
                end
                StDraw: begin
                    lane_d  = lane_fold;
                    gap_d   = gap_new;
                    valid_d = 1'b1;
                    state_d = StOffer;
                end
                StOffer: begin
                    if (valid_q && spawn_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = gap_q;
                        state_d = StWait;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            gap_q   <= 8'(GAP_MIN);
            lane_q  <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Self-checking bench for spawn_scheduler; expected spawns are queued at the expiring tick.
// The pause scenario is compiled in only when SPAWN_PAUSE_EN is defined.
module tb_spawn_scheduler;

    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned GAP_MIN   = 8;
    localparam int unsigned GAP_STEP  = 4;

    typedef struct packed {
        logic [1:0] lane;
        logic [3:0] rnd;
        logic [7:0] gap;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic       frame_tick;
`ifdef SPAWN_PAUSE_EN
    logic       pause;
`endif
    logic       spawn_ready;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic [3:0] rnd;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [3:0] m_rnd;
    int         m_gap;

    spawn_scheduler #(
        .NUM_LANES(NUM_LANES),
        .GAP_MIN  (GAP_MIN),
        .GAP_STEP (GAP_STEP),
        .SEED     (4'b1111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .frame_tick (frame_tick),
`ifdef SPAWN_PAUSE_EN
        .pause      (pause),
`endif
        .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid),
        .spawn_lane (spawn_lane),
        .rnd        (rnd),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] m_next(input logic [3:0] r);
        return {r[2:0], r[3] ^ r[0]};
    endfunction

    function automatic logic [1:0] m_lane(input logic [3:0] r);
        int l;
        l = int'(r[1:0]);
        if (l >= int'(NUM_LANES)) l = l - int'(NUM_LANES);
        return 2'(l);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        run         = 1'b0;
        frame_tick  = 1'b0;
        spawn_ready = 1'b0;
`ifdef SPAWN_PAUSE_EN
        pause       = 1'b0;
`endif
        step();
        step();
        rst   = 1'b0;
        m_rnd = 4'b1111;
        m_gap = GAP_MIN;
        sb.delete();
    endtask

    // Sends `gap` ticks, queueing the expected spawn just before the expiring one.
    // Returns observations only: valid seen early, valid in DRAW, valid in first OFFER cycle.
    task automatic spawn_after(input int gap, output bit early, output bit v_draw,
                               output bit v_offer);
        exp_t e;
        early = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (i == gap - 1) begin
                m_rnd  = m_next(m_rnd);
                e.lane = m_lane(m_rnd);
                e.rnd  = m_rnd;
                e.gap  = 8'(GAP_MIN + int'(m_rnd[3:2]) * GAP_STEP);
                sb.push_back(e);
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i < gap - 1) begin
                if (spawn_valid) early = 1'b1;
                step();
                if (spawn_valid) early = 1'b1;
            end
        end
        v_draw = spawn_valid;
        step();
        v_offer = spawn_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
`ifdef SPAWN_PAUSE_EN
        pause = 1'b0;
`endif
        #12;
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", spawn_valid); end
        checks++; if (spawn_lane !== 2'd0) begin errors++; $display("FAIL reset_lane got %0d want 0", spawn_lane); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rnd !== 4'b1111) begin errors++; $display("FAIL reset_rnd got %b want 1111", rnd); end
    endtask

    task automatic test_first_spawn();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        checks++; if (early) begin errors++; $display("FAIL first_early got 1 want 0"); end
        checks++; if (vd !== 1'b0) begin errors++; $display("FAIL first_draw_valid got %b want 0", vd); end
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL first_offer_valid got %b want 1", vo); end
        checks++; if (spawn_lane !== e.lane) begin errors++; $display("FAIL first_lane got %0d want %0d", spawn_lane, e.lane); end
        checks++; if (rnd !== e.rnd) begin errors++; $display("FAIL first_rnd got %b want %b", rnd, e.rnd); end
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL first_pulse got %b want 0", spawn_valid); end
    endtask

    task automatic test_backpressure();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b0;
        step();
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        m_gap = int'(e.gap);
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL bp_offer_valid got %b want 1", vo); end
        for (int c = 0; c < 10; c++) begin
            frame_tick = (c % 2 == 0);
            step();
            checks++;
            if (spawn_valid !== 1'b1 || spawn_lane !== e.lane) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b lane %0d want 1 lane %0d",
                         c, spawn_valid, spawn_lane, e.lane);
            end
        end
        frame_tick  = 1'b0;
        spawn_ready = 1'b1;
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", spawn_valid); end
        spawn_after(m_gap, early, vd, vo);
        e = sb.pop_front();
        checks++; if (early || vo !== 1'b1) begin errors++; $display("FAIL bp_gap early %b valid %b want 0 1", early, vo); end
        checks++; if (spawn_lane !== e.lane) begin errors++; $display("FAIL bp_lane got %0d want %0d", spawn_lane, e.lane); end
        step();
    endtask

    task automatic test_free_run();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            spawn_after(m_gap, early, vd, vo);
            e = sb.pop_front();
            m_gap = int'(e.gap);
            checks++;
            if (early || vd !== 1'b0 || vo !== 1'b1) begin
                errors++;
                $display("FAIL free_timing spawn %0d early %b draw %b offer %b want 0 0 1", k, early, vd, vo);
            end
            checks++;
            if (spawn_lane !== e.lane || rnd !== e.rnd) begin
                errors++;
                $display("FAIL free_spawn %0d got lane %0d rnd %b want lane %0d rnd %b",
                         k, spawn_lane, rnd, e.lane, e.rnd);
            end
            step();
            checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL free_pulse %0d got %b want 0", k, spawn_valid); end
        end
    endtask

    task automatic test_run_drop();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b0;
        step();
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL drop_offer got %b want 1", vo); end
        // Handshake and run drop land on the same edge.
        spawn_ready = 1'b1; run = 1'b0;
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", spawn_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
        run = 1'b1; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rerun_busy got %b want 1", busy); end
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        checks++; if (early || vo !== 1'b1) begin errors++; $display("FAIL rerun_timing early %b valid %b want 0 1", early, vo); end
        checks++;
        if (rnd !== e.rnd || spawn_lane !== e.lane) begin
            errors++;
            $display("FAIL rerun_spawn got lane %0d rnd %b want lane %0d rnd %b", spawn_lane, rnd, e.lane, e.rnd);
        end
        step();
    endtask

    task automatic test_async_reset();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b1;
        step();
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_lane !== 2'd0 || rnd !== 4'b1111) begin
            errors++;
            $display("FAIL arst_values got valid %b busy %b lane %0d rnd %b want 0 0 0 1111",
                     spawn_valid, busy, spawn_lane, rnd);
        end
        #2 rst = 1'b0;
        m_rnd = 4'b1111;
        sb.delete();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart_busy got %b want 1", busy); end
        spawn_after(GAP_MIN, early, vd, vo);
        e = sb.pop_front();
        checks++; if (early || vd !== 1'b0 || vo !== 1'b1) begin errors++; $display("FAIL arst_timing early %b draw %b offer %b", early, vd, vo); end
        checks++;
        if (spawn_lane !== e.lane || rnd !== e.rnd) begin
            errors++;
            $display("FAIL arst_spawn got lane %0d rnd %b want lane %0d rnd %b", spawn_lane, rnd, e.lane, e.rnd);
        end
        step();
    endtask

`ifdef SPAWN_PAUSE_EN
    task automatic test_pause();
        bit   early, vd, vo;
        exp_t e;
        do_reset();
        run = 1'b1; spawn_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        pause = 1'b0;
        spawn_after(GAP_MIN - 3, early, vd, vo);
        e = sb.pop_front();
        checks++; if (early || vd !== 1'b0 || vo !== 1'b1) begin errors++; $display("FAIL pause_timing early %b draw %b offer %b", early, vd, vo); end
        checks++; if (spawn_lane !== e.lane) begin errors++; $display("FAIL pause_lane got %0d want %0d", spawn_lane, e.lane); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_first_spawn();
        test_backpressure();
        test_free_run();
        test_run_drop();
        test_async_reset();
`ifdef SPAWN_PAUSE_EN
        test_pause();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
